ahb_cmd_master: RTL

- Upstream AHB master stage that drives the memory sub-system's AHB slave port.
- Accepts simple register/memory commands (address, read/write, write data) over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command as a single 32-bit AHB transfer, then returns read data and status over a valid/ready response channel.
- Used by the test harness and by the boot loader to program the offset/range mapping registers and load memory.

---
 rtl/ahb_cmd_master_pkg.sv | 33 +++
 rtl/ahb_cmd_master_if.sv | 43 ++++
 rtl/ahb_cmd_master_fifo.sv | 49 ++++
 rtl/ahb_cmd_master.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ahb_cmd_master_pkg.sv
// Shared AHB-lite encodings, command record and FSM state codes for ahb_cmd_master.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package ahb_cmd_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // One buffered command: byte address, direction and write data.
  typedef struct packed {
    logic [30:0] addr;
    logic        write;
    logic [31:0] wdata;
  } ahb_cmd_t;

  // FSM state codes; kept as plain vectors so legacy code can compare them directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // True for transfer types that carry an address phase the slave must act on.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_cmd_master_if.sv
// Command/response handshake plus AHB-lite master bus, grouped for ahb_cmd_master.
// Latency: none, wiring only.
// Backpressure: req_ready and rsp_ready carry the two valid/ready handshakes.
interface ahb_cmd_master_if;

  logic        req_valid;
  logic        req_ready;
  logic [30:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [30:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  HREADY, HRDATA, HRESP,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HSEL
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output HREADY, HRDATA, HRESP,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HSEL
  );

endinterface

// File: rtl/ahb_cmd_master_fifo.sv
// Generic show-ahead synchronous FIFO of WIDTH-bit entries, DEPTH deep (power of two).
// Latency: a pushed entry appears on rd_dat the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module ahb_cmd_master_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset discards any buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-lite single-transfer master: buffers commands, issues one word transfer at a time, returns data/status.
// Latency: command offered in cycle N yields rsp_valid in cycle N+4 with zero wait states.
// Backpressure: req_ready falls when the command FIFO is full; an unconsumed response parks the FSM in RESP.
module ahb_cmd_master
  import ahb_cmd_master_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_cmd_master_if.master bus
);

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] to_cnt;
  ahb_cmd_t      push_cmd;
  ahb_cmd_t      head_cmd;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [30:0]   haddr_q;
  logic          hwrite_q;
  logic [31:0]   wdata_hold;
  logic [31:0]   hwdata_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic          in_xfer;
  logic          timed_out;
  logic          data_done;
  logic          unused_hresp;

  assign push_cmd  = {bus.req_addr, bus.req_write, bus.req_wdata};
  assign fifo_push = bus.req_valid && bus.req_ready;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  ahb_cmd_master_fifo #(
    .WIDTH ($bits(ahb_cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (HCLK),
    .rst    (HRESET),
    .push   (fifo_push),
    .wr_dat (push_cmd),
    .pop    (fifo_pop),
    .rd_dat (head_cmd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Abort fires on the edge that ends the TIMEOUT-th consecutive wait state of a phase.
  assign in_xfer   = (state == ST_ADDR) || (state == ST_DATA);
  assign timed_out = in_xfer && !bus.HREADY && (to_cnt == TO_LAST);
  assign data_done = (state == ST_DATA) && bus.HREADY;

  // Only the error bit of HRESP matters to a single-transfer master.
  assign unused_hresp = bus.HRESP[1];

  // Transfer sequencing and the per-phase wait-state timer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (!fifo_empty) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (bus.HREADY) begin
            state  <= ST_DATA;
            to_cnt <= '0;
          end else if (timed_out) begin
            state  <= ST_RESP;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bus.HREADY || timed_out) begin
            state  <= ST_RESP;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        default: begin
          to_cnt <= '0;
          if (bus.rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address/control latched at pop; write data moves onto HWDATA as the address phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      wdata_hold <= '0;
      hwdata_q   <= '0;
    end else begin
      if (fifo_pop) begin
        haddr_q    <= head_cmd.addr;
        hwrite_q   <= head_cmd.write;
        wdata_hold <= head_cmd.wdata;
      end
      if ((state == ST_ADDR) && bus.HREADY) hwdata_q <= wdata_hold;
    end
  end

  // Response capture at data-phase completion or abort; held until the consumer takes it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (data_done) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= (hwrite_q || bus.HRESP[0]) ? 32'h0 : bus.HRDATA;
      rsp_err_q   <= bus.HRESP[0];
    end else if (timed_out) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b1;
    end else if ((state == ST_RESP) && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign bus.HADDR  = haddr_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HSEL   = in_xfer;
  assign bus.HWDATA = hwdata_q;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HPROT  = HPROT_DEFAULT;

endmodule
